// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares one synchronous-read data-memory port between the CPU MEM stage
//   (requester 0) and an auxiliary loader/debug master (requester 1).
//   One access is latched at a time. Stores complete one cycle after grant,
//   loads two cycles after grant. Misaligned or illegal accesses are
//   answered with done+err and never reach memory.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req*/we*/op*/addr*/wdata*  per-requester request fields (held until gnt)
//   gnt*, done*, err*     one-cycle pulses back to each requester
//   rdata*                load result (valid with done, holds otherwise)
//   m_addr/m_byteen/m_wdata/m_re  memory request, live only in ISSUE
//   m_rdata               memory read word, valid the cycle after m_re
//
// state  | meaning
// IDLE   | arbitrate, pulse gnt, latch winner's request
// ISSUE  | drive memory port; finish stores and errors
// RDATA  | capture read word, extract/extend lane, finish load

module dm_port_arbiter #(
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] m_addr,
  output logic [3:0]  m_byteen,
  output logic [31:0] m_wdata,
  output logic        m_re,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RDATA = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_last;     // requester granted most recently
  logic        r_owner;    // requester owning the current access
  logic        r_we;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_any;
  logic        w_pick;
  logic        w_bad;
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [3:0]  w_be;
  logic [31:0] w_wd;

  assign w_any = req0 | req1;

  // On a tie the round-robin winner is the requester not granted last.
  always_comb begin
    w_pick = req1;
    if (req0 && req1) begin
      w_pick = CPU_PRIO ? 1'b0 : ~r_last;
    end
  end

  assign w_bad = (r_op > 3'd4) ||
                 ((r_op == 3'd0) && (r_addr[1:0] != 2'b00)) ||
                 (((r_op == 3'd3) || (r_op == 3'd4)) && r_addr[0]);

  // Store lane placement.
  always_comb begin
    w_be = 4'b0000;
    w_wd = 32'h0;
    case (r_op)
      3'd0: begin
        w_be = 4'b1111;
        w_wd = r_wdata;
      end
      3'd1, 3'd2: begin
        w_be = 4'b0001 << r_addr[1:0];
        w_wd = {24'h0, r_wdata[7:0]} << {r_addr[1:0], 3'b000};
      end
      3'd3, 3'd4: begin
        w_be = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wd = r_addr[1] ? {r_wdata[15:0], 16'h0} : {16'h0, r_wdata[15:0]};
      end
      default: begin
        w_be = 4'b0000;
        w_wd = 32'h0;
      end
    endcase
  end

  // Load lane extraction and extension.
  assign w_shift = m_rdata >> {r_addr[1:0], 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = r_addr[1] ? m_rdata[31:16] : m_rdata[15:0];

  always_comb begin
    w_ext = m_rdata;
    case (r_op)
      3'd1:    w_ext = {{24{w_byte[7]}}, w_byte};
      3'd2:    w_ext = {24'h0, w_byte};
      3'd3:    w_ext = {{16{w_half[15]}}, w_half};
      3'd4:    w_ext = {16'h0, w_half};
      default: w_ext = m_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_op     <= 3'd0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata0 <= 32'h0;
      r_rdata1 <= 32'h0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_any) begin
        r_last  <= w_pick;
        r_owner <= w_pick;
        r_we    <= w_pick ? we1    : we0;
        r_op    <= w_pick ? op1    : op0;
        r_addr  <= w_pick ? addr1  : addr0;
        r_wdata <= w_pick ? wdata1 : wdata0;
      end
      if (r_state == S_RDATA) begin
        if (r_owner) r_rdata1 <= w_ext;
        else         r_rdata0 <= w_ext;
      end
    end
  end

  // Outputs are suppressed while reset is high so an abandoned access
  // cannot produce a stray done or an unhonoured gnt.
  always_comb begin
    w_next   = r_state;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;
    err0     = 1'b0;
    err1     = 1'b0;
    rdata0   = r_rdata0;
    rdata1   = r_rdata1;
    m_addr   = 32'h0;
    m_byteen = 4'b0000;
    m_wdata  = 32'h0;
    m_re     = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            gnt0   = ~w_pick;
            gnt1   = w_pick;
            w_next = S_ISSUE;
          end
        end
        S_ISSUE: begin
          m_addr = {r_addr[31:2], 2'b00};
          if (w_bad) begin
            done0  = ~r_owner;
            done1  = r_owner;
            err0   = ~r_owner;
            err1   = r_owner;
            w_next = S_IDLE;
          end else if (r_we) begin
            m_byteen = w_be;
            m_wdata  = w_wd;
            done0    = ~r_owner;
            done1    = r_owner;
            w_next   = S_IDLE;
          end else begin
            m_re   = 1'b1;
            w_next = S_RDATA;
          end
        end
        S_RDATA: begin
          done0  = ~r_owner;
          done1  = r_owner;
          if (r_owner) rdata1 = w_ext;
          else         rdata0 = w_ext;
          w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter. Instance a is round-robin, instance b
// has CPU priority; both share the same stimulus.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [2:0]  op0, op1;
  logic [31:0] addr0, addr1, wdata0, wdata1, m_rdata;

  logic        gnt0_a, gnt1_a, done0_a, done1_a, err0_a, err1_a, m_re_a;
  logic [31:0] rdata0_a, rdata1_a, m_addr_a, m_wdata_a;
  logic [3:0]  m_byteen_a;
  logic        gnt0_b, gnt1_b, done0_b, done1_b, err0_b, err1_b, m_re_b;
  logic [31:0] rdata0_b, rdata1_b, m_addr_b, m_wdata_b;
  logic [3:0]  m_byteen_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.CPU_PRIO(1'b0)) u_a (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .op0(op0), .op1(op1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .done0(done0_a), .done1(done1_a),
    .err0(err0_a), .err1(err1_a), .rdata0(rdata0_a), .rdata1(rdata1_a),
    .m_addr(m_addr_a), .m_byteen(m_byteen_a), .m_wdata(m_wdata_a),
    .m_re(m_re_a), .m_rdata(m_rdata)
  );

  dm_port_arbiter #(.CPU_PRIO(1'b1)) u_b (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .op0(op0), .op1(op1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
    .err0(err0_b), .err1(err1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
    .m_addr(m_addr_b), .m_byteen(m_byteen_b), .m_wdata(m_wdata_b),
    .m_re(m_re_b), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; op0 = 0; op1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; m_rdata = 0;

    // Reset: outputs zero, no grant even with a request pending.
    repeat (2) @(negedge clk);
    req0 = 1'b1;
    #1;
    chk("rst_gnt0", 32'(gnt0_a), 0);
    chk("rst_done0", 32'(done0_a), 0);
    chk("rst_err0", 32'(err0_a), 0);
    chk("rst_rdata0", rdata0_a, 0);
    chk("rst_rdata1", rdata1_a, 0);
    chk("rst_maddr", m_addr_a, 0);
    chk("rst_byteen", 32'(m_byteen_a), 0);
    chk("rst_mwdata", m_wdata_a, 0);
    chk("rst_mre", 32'(m_re_a), 0);

    // Store byte at 0x13.
    @(negedge clk);
    reset = 1'b0; req0 = 1; we0 = 1; op0 = 3'b001; addr0 = 32'h13; wdata0 = 32'h1234_56AB;
    #1;
    chk("sb_gnt0", 32'(gnt0_a), 1);
    chk("sb_gnt1", 32'(gnt1_a), 0);
    @(negedge clk); req0 = 0; #1;
    chk("sb_maddr", m_addr_a, 32'h10);
    chk("sb_byteen", 32'(m_byteen_a), 32'h8);
    chk("sb_mwdata", m_wdata_a, 32'hAB00_0000);
    chk("sb_done0", 32'(done0_a), 1);
    chk("sb_err0", 32'(err0_a), 0);
    chk("sb_mre", 32'(m_re_a), 0);
    @(negedge clk); #1;
    chk("sb_after_done0", 32'(done0_a), 0);
    chk("sb_after_byteen", 32'(m_byteen_a), 0);

    // Load half signed at 0x22 by requester 1.
    @(negedge clk);
    req1 = 1; we1 = 0; op1 = 3'b011; addr1 = 32'h22;
    #1;
    chk("lh_gnt1", 32'(gnt1_a), 1);
    @(negedge clk); req1 = 0; #1;
    chk("lh_mre", 32'(m_re_a), 1);
    chk("lh_maddr", m_addr_a, 32'h20);
    chk("lh_byteen", 32'(m_byteen_a), 0);
    chk("lh_early_done1", 32'(done1_a), 0);
    @(negedge clk); m_rdata = 32'h8001_0000; #1;
    chk("lh_done1", 32'(done1_a), 1);
    chk("lh_err1", 32'(err1_a), 0);
    chk("lh_rdata1", rdata1_a, 32'hFFFF_8001);
    chk("lh_rdata0_hold", rdata0_a, 0);
    chk("lh_mre_off", 32'(m_re_a), 0);

    // Same access, unsigned.
    @(negedge clk); m_rdata = 0; req1 = 1; op1 = 3'b100; #1;
    chk("lhu_gnt1", 32'(gnt1_a), 1);
    @(negedge clk); req1 = 0;
    @(negedge clk); m_rdata = 32'h8001_0000; #1;
    chk("lhu_done1", 32'(done1_a), 1);
    chk("lhu_rdata1", rdata1_a, 32'h0000_8001);
    @(negedge clk); m_rdata = 0; #1;
    chk("lhu_hold_rdata1", rdata1_a, 32'h0000_8001);
    chk("lhu_hold_done1", 32'(done1_a), 0);

    // Load byte signed, lane 1.
    @(negedge clk); req0 = 1; we0 = 0; op0 = 3'b001; addr0 = 32'h01; #1;
    chk("lb_gnt0", 32'(gnt0_a), 1);
    @(negedge clk); req0 = 0;
    @(negedge clk); m_rdata = 32'h0000_8000; #1;
    chk("lb_done0", 32'(done0_a), 1);
    chk("lb_rdata0", rdata0_a, 32'hFFFF_FF80);

    // Load byte unsigned, lane 2.
    @(negedge clk); m_rdata = 0; req0 = 1; op0 = 3'b010; addr0 = 32'h02; #1;
    chk("lbu_gnt0", 32'(gnt0_a), 1);
    @(negedge clk); req0 = 0;
    @(negedge clk); m_rdata = 32'h00AB_0000; #1;
    chk("lbu_rdata0", rdata0_a, 32'h0000_00AB);
    chk("lbu_rdata1_hold", rdata1_a, 32'h0000_8001);

    // Store half to upper half.
    @(negedge clk); m_rdata = 0;
    req1 = 1; we1 = 1; op1 = 3'b011; addr1 = 32'h02; wdata1 = 32'hDEAD_BEEF; #1;
    chk("sh_gnt1", 32'(gnt1_a), 1);
    @(negedge clk); req1 = 0; #1;
    chk("sh_byteen", 32'(m_byteen_a), 32'hC);
    chk("sh_mwdata", m_wdata_a, 32'hBEEF_0000);
    chk("sh_done1", 32'(done1_a), 1);
    chk("sh_err1", 32'(err1_a), 0);

    // Both requesters held with word stores.
    @(negedge clk);
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; op0 = 0; op1 = 0;
    addr0 = 32'h4; addr1 = 32'h8; wdata0 = 32'h1111_1111; wdata1 = 32'h2222_2222;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("rr_gnt0_c%0d", c), 32'(gnt0_a), 32'((c % 4) == 0));
      chk($sformatf("rr_gnt1_c%0d", c), 32'(gnt1_a), 32'((c % 4) == 2));
      chk($sformatf("rr_done0_c%0d", c), 32'(done0_a), 32'((c % 4) == 1));
      chk($sformatf("pr_gnt0_c%0d", c), 32'(gnt0_b), 32'((c % 2) == 0));
      chk($sformatf("pr_gnt1_c%0d", c), 32'(gnt1_b), 0);
    end
    @(negedge clk); req0 = 0; req1 = 0;

    // Misaligned word store at 0x06.
    @(negedge clk); req0 = 1; we0 = 1; op0 = 3'b000; addr0 = 32'h06; #1;
    chk("mw_gnt0", 32'(gnt0_a), 1);
    @(negedge clk); req0 = 0; #1;
    chk("mw_done0", 32'(done0_a), 1);
    chk("mw_err0", 32'(err0_a), 1);
    chk("mw_byteen", 32'(m_byteen_a), 0);
    chk("mw_mre", 32'(m_re_a), 0);
    @(negedge clk); #1;
    chk("mw_after_done0", 32'(done0_a), 0);

    // Misaligned half load at 0x03.
    @(negedge clk); req1 = 1; we1 = 0; op1 = 3'b011; addr1 = 32'h03; #1;
    chk("mh_gnt1", 32'(gnt1_a), 1);
    @(negedge clk); req1 = 0; #1;
    chk("mh_done1", 32'(done1_a), 1);
    chk("mh_err1", 32'(err1_a), 1);
    chk("mh_mre", 32'(m_re_a), 0);
    chk("mh_byteen", 32'(m_byteen_a), 0);
    @(negedge clk); #1;
    chk("mh_no_rdata_done1", 32'(done1_a), 0);
    chk("mh_no_rdata_mre", 32'(m_re_a), 0);

    // Illegal op 111 store.
    @(negedge clk); req0 = 1; we0 = 1; op0 = 3'b111; addr0 = 32'h0; #1;
    chk("il_gnt0", 32'(gnt0_a), 1);
    @(negedge clk); req0 = 0; #1;
    chk("il_done0", 32'(done0_a), 1);
    chk("il_err0", 32'(err0_a), 1);
    chk("il_byteen", 32'(m_byteen_a), 0);

    // Reset while a load is in flight; pointer was left at requester 0.
    @(negedge clk); req0 = 1; we0 = 0; op0 = 3'b000; addr0 = 32'h08; #1;
    chk("rl_gnt0", 32'(gnt0_a), 1);
    @(negedge clk); req0 = 0; #1;
    chk("rl_mre", 32'(m_re_a), 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; m_rdata = 32'hFFFF_FFFF; #1;
    chk("rl_done0", 32'(done0_a), 0);
    chk("rl_err0", 32'(err0_a), 0);
    chk("rl_rdata0", rdata0_a, 0);
    chk("rl_rdata1", rdata1_a, 0);
    chk("rl_mre_off", 32'(m_re_a), 0);
    chk("rl_maddr", m_addr_a, 0);
    @(negedge clk); m_rdata = 0;
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; op0 = 0; op1 = 0; addr0 = 0; addr1 = 0; #1;
    chk("rl_tie_gnt0", 32'(gnt0_a), 1);
    chk("rl_tie_gnt1", 32'(gnt1_a), 0);
    @(negedge clk); req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
